// File: rtl/convnet_pkg.sv
// Shared types and helpers for the convolution datapath blocks.
package convnet_pkg;

  // Collector phases: accepting the stream, or frozen and serving reads.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } collector_state_t;

  typedef struct packed {
    int unsigned i;
    int unsigned j;
  } raster_pos_t;

  // Row-major raster step: column fastest, whole matrix wraps back to (0,0).
  function automatic raster_pos_t raster_next(input int unsigned i, input int unsigned j,
                                              input int unsigned lin, input int unsigned col);
    raster_pos_t p;
    if (j == col - 1) begin
      p.j = 0;
      p.i = (i == lin - 1) ? 0 : i + 1;
    end else begin
      p.i = i;
      p.j = j + 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order write position counter; owns position and wrap for the collector.
module raster_counter
  import convnet_pkg::*;
#(
  parameter int unsigned SIZELin   = 3,
  parameter int unsigned SIZECol   = 3,
  parameter int unsigned WIDTH_BIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step,
  output logic [WIDTH_BIT-1:0] wr_i,
  output logic [WIDTH_BIT-1:0] wr_j,
  output logic                 last
);

  logic [WIDTH_BIT-1:0] wr_i_q, wr_i_d;
  logic [WIDTH_BIT-1:0] wr_j_q, wr_j_d;
  raster_pos_t          pos_next;

  // Next position when a step is taken; hold otherwise.
  always_comb begin
    pos_next = raster_next(32'(wr_i_q), 32'(wr_j_q), SIZELin, SIZECol);
    wr_i_d   = wr_i_q;
    wr_j_d   = wr_j_q;
    if (step) begin
      wr_i_d = WIDTH_BIT'(pos_next.i);
      wr_j_d = WIDTH_BIT'(pos_next.j);
    end
  end

  // Position register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_i_q <= '0;
      wr_j_q <= '0;
    end else begin
      wr_i_q <= wr_i_d;
      wr_j_q <= wr_j_d;
    end
  end

  assign wr_i = wr_i_q;
  assign wr_j = wr_j_q;
  assign last = (wr_i_q == WIDTH_BIT'(SIZELin - 1)) && (wr_j_q == WIDTH_BIT'(SIZECol - 1));

endmodule

// File: rtl/matrix_collector.sv
// Collects a raster-order stream into a register matrix, then freezes it and
// serves registered random reads until released for the next matrix.
// The re-arm input is named matrix_release because "release" is a reserved word.
module matrix_collector
  import convnet_pkg::*;
#(
  parameter int unsigned SIZELin    = 3,
  parameter int unsigned SIZECol    = 3,
  parameter int unsigned WIDTH_BIT  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [WIDTH_BIT-1:0]  wr_i,
  output logic [WIDTH_BIT-1:0]  wr_j,
  output logic                  full,
  input  logic                  matrix_release,
  input  logic                  rd_en,
  input  logic [WIDTH_BIT-1:0]  rd_i,
  input  logic [WIDTH_BIT-1:0]  rd_j,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  // Indices must fit the counters with headroom for the all-ones value.
  if ((SIZELin < 1) || (SIZECol < 1) ||
      (SIZELin > (2 ** WIDTH_BIT) - 1) || (SIZECol > (2 ** WIDTH_BIT) - 1)) begin : g_size_check
    $fatal(1, "matrix_collector: SIZELin/SIZECol out of range for WIDTH_BIT");
  end

  collector_state_t      state_q, state_d;
  logic                  step;
  logic                  last;
  logic [DATA_WIDTH-1:0] mem_q [SIZELin][SIZECol];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  assign in_ready = (state_q == FILL);
  assign full     = (state_q == HOLD);
  assign step     = in_valid && in_ready;

  raster_counter #(
    .SIZELin  (SIZELin),
    .SIZECol  (SIZECol),
    .WIDTH_BIT(WIDTH_BIT)
  ) u_raster_counter (
    .clock(clock),
    .reset(reset),
    .step (step),
    .wr_i (wr_i),
    .wr_j (wr_j),
    .last (last)
  );

  // Freeze after the final cell is written; re-arm on release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (step && last) state_d = HOLD;
      HOLD:    if (matrix_release) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Matrix storage: cleared on reset, written at the current raster position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(SIZELin); r++) begin
        for (int c = 0; c < int'(SIZECol); c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (step) begin
      for (int r = 0; r < int'(SIZELin); r++) begin
        for (int c = 0; c < int'(SIZECol); c++) begin
          if ((wr_i == WIDTH_BIT'(r)) && (wr_j == WIDTH_BIT'(c))) begin
            mem_q[r][c] <= in_data;
          end
        end
      end
    end
  end

  // Read select; out-of-range coordinates match no cell and return zero.
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < int'(SIZELin); r++) begin
      for (int c = 0; c < int'(SIZECol); c++) begin
        if ((rd_i == WIDTH_BIT'(r)) && (rd_j == WIDTH_BIT'(c))) begin
          rd_mux = mem_q[r][c];
        end
      end
    end
  end

  // Registered read port; only served while the matrix is frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en && (state_q == HOLD)) begin
      rd_data_q  <= rd_mux;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_matrix_collector.sv
// Directed bench for matrix_collector (3x3, 8-bit indices and data).
module tb_matrix_collector;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] wr_i;
  logic [7:0] wr_j;
  logic       full;
  logic       matrix_release;
  logic       rd_en;
  logic [7:0] rd_i;
  logic [7:0] rd_j;
  logic [7:0] rd_data;
  logic       rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  matrix_collector #(
    .SIZELin   (3),
    .SIZECol   (3),
    .WIDTH_BIT (8),
    .DATA_WIDTH(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .wr_i          (wr_i),
    .wr_j          (wr_j),
    .full          (full),
    .matrix_release(matrix_release),
    .rd_en         (rd_en),
    .rd_i          (rd_i),
    .rd_j          (rd_j),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a one-cycle read and check the registered result.
  task automatic read_check(input string tag, input logic [7:0] i, input logic [7:0] j,
                            input logic [7:0] exp_data, input logic exp_valid);
    rd_en = 1'b1;
    rd_i  = i;
    rd_j  = j;
    tick();
    rd_en = 1'b0;
    check({tag, "_data"}, 32'(rd_data), 32'(exp_data));
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
  endtask

  task automatic fill_1_to_9(input string tag);
    for (int k = 1; k <= 8; k++) push(8'(k));
    check({tag, "_pos8_i"}, 32'(wr_i), 32'd2);
    check({tag, "_pos8_j"}, 32'(wr_j), 32'd2);
    check({tag, "_notfull8"}, 32'(full), 32'd0);
    push(8'd9);
    check({tag, "_full"}, 32'(full), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wrap_i"}, 32'(wr_i), 32'd0);
    check({tag, "_wrap_j"}, 32'(wr_j), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    matrix_release = 1'b0;
    rd_en          = 1'b0;
    rd_i           = '0;
    rd_j           = '0;
    #2;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_wr_i", 32'(wr_i), 32'd0);
    check("rst_wr_j", 32'(wr_j), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: back-to-back fill, then read (1,2).
    fill_1_to_9("s1");
    read_check("s1_rd12", 8'd1, 8'd2, 8'd6, 1'b1);
    tick();
    check("s1_rd_pulse", 32'(rd_valid), 32'd0);

    // 2: writes ignored while frozen.
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int k = 0; k < 5; k++) tick();
    check("s2_ready", 32'(in_ready), 32'd0);
    check("s2_wr_j", 32'(wr_j), 32'd0);
    in_valid = 1'b0;
    read_check("s2_rd00", 8'd0, 8'd0, 8'd1, 1'b1);

    // 3: release, then fill 10..18 with random gaps.
    matrix_release = 1'b1;
    tick();
    matrix_release = 1'b0;
    check("s3_rel_ready", 32'(in_ready), 32'd1);
    check("s3_rel_full", 32'(full), 32'd0);
    for (int k = 10; k <= 18; k++) begin
      int gaps;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) tick();
      if (k == 18) check("s3_notfull_pre", 32'(full), 32'd0);
      push(8'(k));
    end
    check("s3_full", 32'(full), 32'd1);
    read_check("s3_rd22", 8'd2, 8'd2, 8'd18, 1'b1);
    read_check("s3_rd01", 8'd0, 8'd1, 8'd11, 1'b1);
    read_check("s3_rd10", 8'd1, 8'd0, 8'd13, 1'b1);

    // 4: out-of-range reads, then a read attempt during fill.
    read_check("s4_oor30", 8'd3, 8'd0, 8'd0, 1'b1);
    read_check("s4_oor03", 8'd0, 8'd3, 8'd0, 1'b1);
    read_check("s4_rd22", 8'd2, 8'd2, 8'd18, 1'b1);
    matrix_release = 1'b1;
    tick();
    matrix_release = 1'b0;
    read_check("s4_fill_rd", 8'd1, 8'd1, 8'd18, 1'b0);

    // 5: reset mid-fill is asynchronous, then refill.
    for (int k = 1; k <= 4; k++) push(8'(k));
    check("s5_pos_i", 32'(wr_i), 32'd1);
    check("s5_pos_j", 32'(wr_j), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_wr_i", 32'(wr_i), 32'd0);
    check("s5_async_wr_j", 32'(wr_j), 32'd0);
    check("s5_async_full", 32'(full), 32'd0);
    check("s5_async_rd_data", 32'(rd_data), 32'd0);
    check("s5_async_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    fill_1_to_9("s5");
    read_check("s5_rd12", 8'd1, 8'd2, 8'd6, 1'b1);
    read_check("s5_rd20", 8'd2, 8'd0, 8'd7, 1'b1);

    // 6: read and release in the same frozen cycle.
    rd_en          = 1'b1;
    rd_i           = 8'd1;
    rd_j           = 8'd1;
    matrix_release = 1'b1;
    tick();
    rd_en          = 1'b0;
    matrix_release = 1'b0;
    check("s6_rd_data", 32'(rd_data), 32'd5);
    check("s6_rd_valid", 32'(rd_valid), 32'd1);
    check("s6_ready", 32'(in_ready), 32'd1);
    check("s6_full", 32'(full), 32'd0);
    tick();
    check("s6_rd_pulse", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
